// File: rtl/mem_access_wb.sv
// rtl/mem_access_wb.sv - MEM stage and MEM/WB pipeline register with req/ack data memory access
//
// Purpose:
//   Consumes the EX/MEM register outputs. Non-memory ops pass straight into the
//   MEM/WB register. Aligned loads and stores are issued to a variable-latency
//   data memory over a req/ack handshake while upstream stages are stalled.
//   Misaligned memory ops are dropped, leaving a bubble and a one-cycle misalign pulse.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, an access with no ack for TIMEOUT cycles is abandoned with a
//   one-cycle mem_timeout pulse. When undefined, ACCESS waits indefinitely and
//   mem_timeout is tied low.
//
// Ports:
//   clock, rst                - rising-edge clock, asynchronous active-low reset
//   WB, M, ALUOut, WriteData,
//   RegRD                     - EX/MEM register outputs (WB: RegWrite/MemtoReg, M: Branch/MemRead/MemWrite)
//   stall                     - combinational freeze of EX/MEM and earlier stages
//   mem_req, mem_we, mem_addr,
//   mem_wdata                 - registered data memory request
//   mem_rdata, mem_ack        - memory load data and one-cycle completion strobe
//   WBreg, ALUreg, ReadDataReg,
//   RegRDreg                  - MEM/WB register outputs
//   misalign, mem_timeout     - one-cycle error pulses
module mem_access_wb #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [1:0]        WB,
  input  logic [2:0]        M,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [REG_W-1:0]  RegRD,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        WBreg,
  output logic [DATA_W-1:0] ALUreg,
  output logic [DATA_W-1:0] ReadDataReg,
  output logic [REG_W-1:0]  RegRDreg,
  output logic              misalign,
  output logic              mem_timeout
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic              w_memop;
  logic              w_aligned;
  logic              w_issue;
  logic              w_misalign;
  logic              w_tmo;
  logic              w_unused;

  logic [1:0]        r_wb_l;
  logic [DATA_W-1:0] r_alu_l;
  logic [REG_W-1:0]  r_rd_l;

  // Branch is resolved earlier in the pipeline; it is carried here only as part of M.
  assign w_unused   = M[2] & (TIMEOUT > 0);

  assign w_memop    = M[1] | M[0];
  assign w_aligned  = (ALUOut[1:0] == 2'b00);
  assign w_issue    = (r_state == S_IDLE) && w_memop && w_aligned;
  assign w_misalign = (r_state == S_IDLE) && w_memop && !w_aligned;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  // Ack in the final allowed cycle wins over the timeout.
  assign w_tmo = (r_state == S_ACCESS) && !mem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo;
      if (w_issue) begin
        r_cnt <= '0;
      end else if ((r_state == S_ACCESS) && !mem_ack && !w_tmo) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign mem_timeout = r_timeout;
`else
  assign w_tmo       = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Stall drops in the ack (or timeout) cycle so EX/MEM advances on the same
  // edge that retires the access into MEM/WB.
  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          stall        = 1'b1;
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_ack || w_tmo) begin
          w_next_state = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      WBreg       <= '0;
      ALUreg      <= '0;
      ReadDataReg <= '0;
      RegRDreg    <= '0;
      misalign    <= 1'b0;
      r_wb_l      <= '0;
      r_alu_l     <= '0;
      r_rd_l      <= '0;
    end else begin
      misalign <= w_misalign;
      case (r_state)
        S_IDLE: begin
          if (!w_memop) begin
            WBreg       <= WB;
            ALUreg      <= ALUOut;
            RegRDreg    <= RegRD;
            ReadDataReg <= '0;
          end else begin
            // Both a misaligned drop and a fresh issue leave a bubble in MEM/WB.
            WBreg       <= '0;
            ALUreg      <= '0;
            RegRDreg    <= '0;
            ReadDataReg <= '0;
            if (w_aligned) begin
              r_wb_l    <= WB;
              r_alu_l   <= ALUOut;
              r_rd_l    <= RegRD;
              mem_req   <= 1'b1;
              mem_we    <= M[0];
              mem_addr  <= ALUOut;
              mem_wdata <= WriteData;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            WBreg    <= r_wb_l;
            ALUreg   <= r_alu_l;
            RegRDreg <= r_rd_l;
            // Keep load data zero unless writeback will actually select it.
            ReadDataReg <= (!mem_we && r_wb_l[0]) ? mem_rdata : '0;
          end else begin
            WBreg       <= '0;
            ALUreg      <= '0;
            RegRDreg    <= '0;
            ReadDataReg <= '0;
            if (w_tmo) begin
              mem_req <= 1'b0;
            end
          end
        end
        default: begin
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_wb.sv
// tb/tb_mem_access_wb.sv - self-checking bench for mem_access_wb
`timescale 1ns/1ps
module tb_mem_access_wb;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int TIMEOUT = 16;

  logic              clock = 1'b0;
  logic              rst;
  logic [1:0]        WB;
  logic [2:0]        M;
  logic [DATA_W-1:0] ALUOut;
  logic [DATA_W-1:0] WriteData;
  logic [REG_W-1:0]  RegRD;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [1:0]        WBreg;
  logic [DATA_W-1:0] ALUreg;
  logic [DATA_W-1:0] ReadDataReg;
  logic [REG_W-1:0]  RegRDreg;
  logic              misalign;
  logic              mem_timeout;

  mem_access_wb #(.DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .rst(rst),
    .WB(WB), .M(M), .ALUOut(ALUOut), .WriteData(WriteData), .RegRD(RegRD),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .WBreg(WBreg), .ALUreg(ALUreg), .ReadDataReg(ReadDataReg), .RegRDreg(RegRDreg),
    .misalign(misalign), .mem_timeout(mem_timeout)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_nop(input logic [1:0] wb);
    WB = wb; M = 3'b000; ALUOut = '0; WriteData = '0; RegRD = '0;
  endtask

  // Issue one aligned memory op; ack arrives after wait_n ACCESS cycles without ack.
  task automatic mem_op(input string tag, input logic [1:0] wb, input logic [2:0] m,
                        input logic [31:0] alu, input logic [31:0] wdata, input logic [4:0] rd,
                        input int wait_n, input logic [31:0] rdata,
                        input logic exp_we, input logic [31:0] exp_rdreg);
    int stall_cnt;
    int req_wait;
    stall_cnt = 0;
    req_wait  = 0;
    WB = wb; M = m; ALUOut = alu; WriteData = wdata; RegRD = rd; mem_ack = 1'b0;
    #1;
    chk({tag, " idle stall"}, 32'(stall), 32'd1);
    chk({tag, " idle req"}, 32'(mem_req), 32'd0);
    if (stall) stall_cnt++;
    step();
    chk({tag, " req"}, 32'(mem_req), 32'd1);
    chk({tag, " addr"}, mem_addr, alu);
    chk({tag, " we"}, 32'(mem_we), 32'(exp_we));
    chk({tag, " wdata"}, mem_wdata, wdata);
    chk({tag, " bubble"}, 32'(WBreg), 32'd0);
    for (int i = 0; i < wait_n; i++) begin
      if (mem_req) req_wait++;
      if (stall) stall_cnt++;
      step();
    end
    chk({tag, " addr held"}, mem_addr, alu);
    mem_ack = 1'b1;
    mem_rdata = rdata;
    #1;
    chk({tag, " ack stall"}, 32'(stall), 32'd0);
    chk({tag, " ack req"}, 32'(mem_req), 32'd1);
    chk({tag, " stall cycles"}, 32'(stall_cnt + (stall ? 1 : 0)), 32'(wait_n + 1));
    chk({tag, " req wait cycles"}, 32'(req_wait), 32'(wait_n));
    step();
    mem_ack = 1'b0;
    mem_rdata = '0;
    set_nop(2'b00);
    #1;
    chk({tag, " WBreg"}, 32'(WBreg), 32'(wb));
    chk({tag, " ALUreg"}, ALUreg, alu);
    chk({tag, " RegRDreg"}, 32'(RegRDreg), 32'(rd));
    chk({tag, " ReadDataReg"}, ReadDataReg, exp_rdreg);
    chk({tag, " req drop"}, 32'(mem_req), 32'd0);
    chk({tag, " post stall"}, 32'(stall), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        ack;
    logic [1:0]  e_wb;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
    logic        e_mis;
  } vec_t;

  localparam int NV = 7;
  vec_t v [NV];

  initial begin
    v[0] = '{2'b10, 3'b000, 32'h0000_1234,  5'd5,  1'b0, 2'b10, 32'h0000_1234,  5'd5,  1'b0};
    v[1] = '{2'b11, 3'b100, 32'hCAFE_0003,  5'd7,  1'b0, 2'b11, 32'hCAFE_0003,  5'd7,  1'b0};
    v[2] = '{2'b11, 3'b010, 32'h0000_0041,  5'd9,  1'b0, 2'b00, 32'h0,          5'd0,  1'b1};
    v[3] = '{2'b00, 3'b001, 32'h0000_0082,  5'd3,  1'b0, 2'b00, 32'h0,          5'd0,  1'b1};
    v[4] = '{2'b01, 3'b000, 32'hFFFF_FFFF,  5'd31, 1'b1, 2'b01, 32'hFFFF_FFFF,  5'd31, 1'b0};
    v[5] = '{2'b11, 3'b011, 32'h0000_0043,  5'd4,  1'b0, 2'b00, 32'h0,          5'd0,  1'b1};
    v[6] = '{2'b10, 3'b000, 32'h0000_0055,  5'd12, 1'b1, 2'b10, 32'h0000_0055,  5'd12, 1'b0};

    rst = 1'b0;
    set_nop(2'b00);
    mem_ack = 1'b0;
    mem_rdata = '0;
    #12;
    chk("rst req", 32'(mem_req), 32'd0);
    chk("rst we", 32'(mem_we), 32'd0);
    chk("rst addr", mem_addr, 32'd0);
    chk("rst wdata", mem_wdata, 32'd0);
    chk("rst WBreg", 32'(WBreg), 32'd0);
    chk("rst ALUreg", ALUreg, 32'd0);
    chk("rst ReadDataReg", ReadDataReg, 32'd0);
    chk("rst RegRDreg", 32'(RegRDreg), 32'd0);
    chk("rst misalign", 32'(misalign), 32'd0);
    chk("rst timeout", 32'(mem_timeout), 32'd0);
    rst = 1'b1;

    // Single-cycle IDLE behaviour: pass-through, misaligned drop, ack ignored in IDLE.
    for (int i = 0; i < NV; i++) begin
      WB = v[i].wb; M = v[i].m; ALUOut = v[i].alu; RegRD = v[i].rd;
      WriteData = 32'h5555_AAAA;
      mem_ack = v[i].ack;
      mem_rdata = 32'hBAD0_BAD0;
      #1;
      chk($sformatf("v%0d stall", i), 32'(stall), 32'd0);
      step();
      chk($sformatf("v%0d WBreg", i), 32'(WBreg), 32'(v[i].e_wb));
      chk($sformatf("v%0d ALUreg", i), ALUreg, v[i].e_alu);
      chk($sformatf("v%0d RegRDreg", i), 32'(RegRDreg), 32'(v[i].e_rd));
      chk($sformatf("v%0d ReadDataReg", i), ReadDataReg, 32'd0);
      chk($sformatf("v%0d misalign", i), 32'(misalign), 32'(v[i].e_mis));
      chk($sformatf("v%0d req", i), 32'(mem_req), 32'd0);
    end
    mem_ack = 1'b0;
    set_nop(2'b00);
    step();
    chk("misalign clears", 32'(misalign), 32'd0);

    mem_op("load",      2'b11, 3'b010, 32'h0000_0040, 32'h0,         5'd9, 3, 32'hDEAD_BEEF, 1'b1 ^ 1'b1, 32'hDEAD_BEEF);
    mem_op("store",     2'b00, 3'b001, 32'h0000_0080, 32'hA5A5_A5A5, 5'd0, 1, 32'h1111_1111, 1'b1, 32'h0);
    mem_op("rd+wr",     2'b00, 3'b011, 32'h0000_0084, 32'h0F0F_0F0F, 5'd6, 0, 32'h2222_2222, 1'b1, 32'h0);
    mem_op("load nomr", 2'b10, 3'b010, 32'h0000_0088, 32'h0,         5'd8, 2, 32'h3333_3333, 1'b0, 32'h0);

    // Reset in the middle of an access, then a stray late ack.
    WB = 2'b11; M = 3'b010; ALUOut = 32'h0000_0040; RegRD = 5'd9;
    step();
    step();
    chk("rstmid req before", 32'(mem_req), 32'd1);
    rst = 1'b0;
    set_nop(2'b00);
    #1;
    chk("rstmid req", 32'(mem_req), 32'd0);
    chk("rstmid addr", mem_addr, 32'd0);
    chk("rstmid stall", 32'(stall), 32'd0);
    step();
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_0000;
    step();
    mem_ack = 1'b0;
    chk("late ack ALUreg", ALUreg, 32'd0);
    chk("late ack RegRDreg", 32'(RegRDreg), 32'd0);
    chk("late ack ReadDataReg", ReadDataReg, 32'd0);
    chk("late ack WBreg", 32'(WBreg), 32'd0);
    chk("late ack req", 32'(mem_req), 32'd0);

`ifdef MEM_TIMEOUT_EN
    begin
      int req_cnt;
      int tmo_cnt;
      req_cnt = 0;
      tmo_cnt = 0;
      WB = 2'b11; M = 3'b010; ALUOut = 32'h0000_0100; RegRD = 5'd2;
      step();
      for (int i = 0; i < TIMEOUT + 4; i++) begin
        if (mem_req) req_cnt++;
        if (mem_timeout) tmo_cnt++;
        if (i == TIMEOUT - 1) chk("tmo stall", 32'(stall), 32'd0);
        if (i == TIMEOUT) begin
          chk("tmo pulse", 32'(mem_timeout), 32'd1);
          chk("tmo WBreg", 32'(WBreg), 32'd0);
        end
        step();
        if (i == TIMEOUT - 1) set_nop(2'b10);
      end
      chk("tmo req cycles", 32'(req_cnt), 32'(TIMEOUT));
      chk("tmo pulse count", 32'(tmo_cnt), 32'd1);
      chk("tmo idle stall", 32'(stall), 32'd0);
      chk("tmo passthrough", 32'(WBreg), 32'd2);
    end
`else
    mem_op("long wait", 2'b11, 3'b010, 32'h0000_0100, 32'h0, 5'd2, 40, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D);
    chk("no timeout", 32'(mem_timeout), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
